// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default sizing for the async FIFO.
// Used by the write-side arbiter and the read side.
package pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REQ    = 4;
  localparam int MAX_BURST  = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches upward from ptr, wrapping at NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int GW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      ptr,
  output logic [GW-1:0]      gnt_idx,
  output logic               any
);

  localparam logic [GW:0] NR = (GW+1)'(NUM_REQ);

  logic [GW:0] w_sum;

  // Scan from the farthest offset down so the nearest request wins.
  always_comb begin
    gnt_idx = '0;
    w_sum   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_sum = {1'b0, ptr} + (GW+1)'(i);
      if (w_sum >= NR)
        w_sum = w_sum - NR;
      if (req[w_sum[GW-1:0]])
        gnt_idx = w_sum[GW-1:0];
    end
  end

  assign any = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter: round-robin with burst locking.
// Shares the FIFO write port among NUM_REQ requesters.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = pkg::NUM_REQ,
  parameter int DATA_WIDTH = pkg::DATA_WIDTH,
  parameter int MAX_BURST  = pkg::MAX_BURST
) (
  input  logic                               w_clk,
  input  logic                               wrst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]                 req_last,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic                               f_full,
  output logic                               w_en,
  output logic [DATA_WIDTH-1:0]              w_data,
  output logic [$clog2(NUM_REQ)-1:0]         grant_id,
  output logic                               busy
);

  import pkg::*;

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [GW-1:0] LAST_ID = GW'(NUM_REQ - 1);
  localparam logic [BW-1:0] LAST_BT = BW'(MAX_BURST - 1);

  arb_state_e    r_state;
  logic [GW-1:0] r_gid;
  logic [GW-1:0] r_ptr;
  logic [BW-1:0] r_beat;

  logic [GW-1:0] w_pick;
  logic          w_any;
  logic          w_grant;
  logic          w_xfer;
  logic          w_rel;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_pick (
    .req     (req_valid),
    .ptr     (r_ptr),
    .gnt_idx (w_pick),
    .any     (w_any)
  );

  assign w_grant = (r_state == ARB_GRANT);
  assign w_xfer  = w_grant && req_valid[r_gid] && !f_full;
  assign w_rel   = req_last[r_gid] || (r_beat == LAST_BT);

  // Data path is combinational so f_full gates w_en in the same cycle.
  always_comb begin
    req_ready = '0;
    w_data    = '0;
    if (w_grant) begin
      req_ready[r_gid] = !f_full;
      w_data           = req_data[r_gid];
    end
  end

  assign w_en     = w_xfer;
  assign grant_id = r_gid;
  assign busy     = w_grant;

  // Arbitration FSM: pick, hold for the burst, then one idle bubble.
  always_ff @(posedge w_clk) begin
    if (wrst) begin
      r_state <= ARB_IDLE;
      r_gid   <= '0;
      r_ptr   <= '0;
      r_beat  <= '0;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_gid   <= w_pick;
            r_ptr   <= (w_pick == LAST_ID) ? '0 : w_pick + 1'b1;
            r_beat  <= '0;
            r_state <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (w_xfer) begin
            if (w_rel) begin
              r_beat  <= '0;
              r_state <= ARB_IDLE;
            end else begin
              r_beat  <= r_beat + 1'b1;
            end
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule
